// File: rtl/tictactoe_game_ctrl_if.sv
// rtl/tictactoe_game_ctrl_if.sv - button/tick inputs and game-display outputs of the tic-tac-toe controller
interface tictactoe_game_ctrl_if;
   logic       left;
   logic       right;
   logic       select;
   logic       sec_tick;
   logic [3:0] cursor;
   logic [17:0] board;
   logic       turn;
   logic [1:0] game_state;
   logic [1:0] winner;
   logic [8:0] win_mask;
   logic [3:0] secs_left;

   modport slave (
      input  left, right, select, sec_tick,
      output cursor, board, turn, game_state, winner, win_mask, secs_left
   );

   modport master (
      output left, right, select, sec_tick,
      input  cursor, board, turn, game_state, winner, win_mask, secs_left
   );
endinterface

// File: rtl/tictactoe_game_ctrl.sv
// rtl/tictactoe_game_ctrl.sv - tic-tac-toe game FSM: cursor, board, per-move countdown, win/draw detection
module tictactoe_game_ctrl #(
   parameter int TURN_SECS = 10,
   parameter int OVER_SECS = 3
) (
   input  logic                  clk_100MHz,
   input  logic                  reset,
   tictactoe_game_ctrl_if.slave  bus
);
   typedef enum logic [1:0] {S_IDLE, S_PLAY, S_CHECK, S_OVER} state_t;

   localparam logic [3:0] TURN_LD = 4'(TURN_SECS);
   localparam logic [3:0] OVER_LD = 4'(OVER_SECS);
   // rows, columns, diagonals as cell bitmasks (cell i = bit i)
   localparam logic [8:0] LINES [8] = '{9'h007, 9'h038, 9'h1C0, 9'h049,
                                        9'h092, 9'h124, 9'h111, 9'h054};

   state_t      r_state;
   logic        r_prev_left, r_prev_right, r_prev_select, r_prev_tick;
   logic        r_armed;
   logic [17:0] r_board;
   logic [3:0]  r_cursor;
   logic        r_turn;
   logic [1:0]  r_game_state;
   logic [1:0]  r_winner;
   logic [8:0]  r_win_mask;
   logic [3:0]  r_secs;

   logic        w_left_ev, w_right_ev, w_select_ev, w_tick_ev;
   logic [1:0]  w_mark;
   logic [1:0]  w_cell;
   logic [8:0]  w_mine;
   logic [8:0]  w_filled;
   logic [8:0]  w_line_mask;
   logic [3:0]  w_cursor_dn, w_cursor_up;

   // r_armed blocks the first sample after reset so a held-high input is not an event
   assign w_left_ev   = r_armed & bus.left     & ~r_prev_left;
   assign w_right_ev  = r_armed & bus.right    & ~r_prev_right;
   assign w_select_ev = r_armed & bus.select   & ~r_prev_select;
   assign w_tick_ev   = r_armed & bus.sec_tick & ~r_prev_tick;

   assign w_cursor_dn = (r_cursor == 4'd0) ? 4'd8 : r_cursor - 4'd1;
   assign w_cursor_up = (r_cursor == 4'd8) ? 4'd0 : r_cursor + 4'd1;

   always_comb begin
      w_mark      = r_turn ? 2'b10 : 2'b01;
      w_cell      = r_board[{r_cursor, 1'b0} +: 2];
      w_mine      = '0;
      w_filled    = '0;
      w_line_mask = '0;
      for (int i = 0; i < 9; i++) begin
         w_mine[i]   = (r_board[2*i +: 2] == w_mark);
         w_filled[i] = (r_board[2*i +: 2] != 2'b00);
      end
      for (int l = 0; l < 8; l++) begin
         if ((w_mine & LINES[l]) == LINES[l]) w_line_mask = w_line_mask | LINES[l];
      end
   end

   always_ff @(posedge clk_100MHz or negedge reset) begin
      if (!reset) begin
         r_state       <= S_IDLE;
         r_prev_left   <= 1'b0;
         r_prev_right  <= 1'b0;
         r_prev_select <= 1'b0;
         r_prev_tick   <= 1'b0;
         r_armed       <= 1'b0;
         r_board       <= '0;
         r_cursor      <= 4'd4;
         r_turn        <= 1'b0;
         r_game_state  <= 2'b00;
         r_winner      <= 2'b00;
         r_win_mask    <= '0;
         r_secs        <= 4'd0;
      end else begin
         r_prev_left   <= bus.left;
         r_prev_right  <= bus.right;
         r_prev_select <= bus.select;
         r_prev_tick   <= bus.sec_tick;
         r_armed       <= 1'b1;
         case (r_state)
            S_IDLE: begin
               if (w_select_ev) begin
                  r_board      <= '0;
                  r_turn       <= 1'b0;
                  r_cursor     <= 4'd4;
                  r_secs       <= TURN_LD;
                  r_game_state <= 2'b01;
                  r_state      <= S_PLAY;
               end
            end
            S_PLAY: begin
               if (w_select_ev && (w_cell == 2'b00)) begin
                  r_board[{r_cursor, 1'b0} +: 2] <= w_mark;
                  r_state <= S_CHECK;
               end else begin
                  if (w_left_ev && !w_right_ev)      r_cursor <= w_cursor_dn;
                  else if (w_right_ev && !w_left_ev) r_cursor <= w_cursor_up;
                  if (w_tick_ev) begin
                     if (r_secs == 4'd1) begin
                        r_turn <= ~r_turn;
                        r_secs <= TURN_LD;
                     end else begin
                        r_secs <= r_secs - 4'd1;
                     end
                  end
               end
            end
            S_CHECK: begin
               if (|w_line_mask) begin
                  r_winner     <= w_mark;
                  r_win_mask   <= w_line_mask;
                  r_secs       <= OVER_LD;
                  r_game_state <= 2'b10;
                  r_state      <= S_OVER;
               end else if (&w_filled) begin
                  r_winner     <= 2'b00;
                  r_win_mask   <= '0;
                  r_secs       <= OVER_LD;
                  r_game_state <= 2'b11;
                  r_state      <= S_OVER;
               end else begin
                  r_turn  <= ~r_turn;
                  r_secs  <= TURN_LD;
                  r_state <= S_PLAY;
               end
            end
            S_OVER: begin
               if (w_select_ev || (w_tick_ev && (r_secs == 4'd1))) begin
                  r_board      <= '0;
                  r_winner     <= 2'b00;
                  r_win_mask   <= '0;
                  r_secs       <= 4'd0;
                  r_game_state <= 2'b00;
                  r_state      <= S_IDLE;
               end else if (w_tick_ev) begin
                  r_secs <= r_secs - 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.cursor     = r_cursor;
   assign bus.board      = r_board;
   assign bus.turn       = r_turn;
   assign bus.game_state = r_game_state;
   assign bus.winner     = r_winner;
   assign bus.win_mask   = r_win_mask;
   assign bus.secs_left  = r_secs;
endmodule

// File: doc/tictactoe_game_ctrl.md
TICTACTOE_GAME_CTRL -- requirements
Module: tictactoe_game_ctrl

Interface
REQ-001 SHALL have parameter TURN_SECS, default 10: seconds allowed per move (range 2..15).
REQ-002 SHALL have parameter OVER_SECS, default 3: seconds the result stays on screen before the return to IDLE (range 1..15).
REQ-003 SHALL have port clk_100MHz  in  1  system clock; the only clock in the block.
REQ-004 SHALL have port reset  in  1  asynchronous reset, active-low.
REQ-005 SHALL have port left  in  1  debounced, synchronous level; move cursor down.
REQ-006 SHALL have port right  in  1  debounced, synchronous level; move cursor up.
REQ-007 SHALL have port select  in  1  debounced, synchronous level; place mark, start game or skip result.
REQ-008 SHALL have port sec_tick  in  1  1 Hz square wave from the frequency divider, treated as data only.
REQ-009 SHALL have port cursor  out  4  selected cell, 0..8, row-major.
REQ-010 SHALL have port board  out  18  cell i at bits [2i+1:2i]: 00 empty, 01 X, 10 O.
REQ-011 SHALL have port turn  out  1  player to move: 0 = X, 1 = O.
REQ-012 SHALL have port game_state  out  2  00 IDLE, 01 PLAY, 10 WIN, 11 DRAW.
REQ-013 SHALL have port winner  out  2  01 X, 10 O, 00 none.
REQ-014 SHALL have port win_mask  out  9  cells on completed winning lines, for highlight by the text painter.
REQ-015 SHALL have port secs_left  out  4  countdown value for display.

Function
REQ-016 SHALL detect events on left, right, select and sec_tick as rising edges: current sample 1 and registered previous sample 0; previous-sample registers reset to 0.
REQ-017 SHALL act on an event at the clock edge where it is detected; outputs reflect the event immediately after that edge, with no extra latency.
REQ-018 SHALL implement FSM states IDLE, PLAY, CHECK and OVER; OVER drives game_state 10 or 11.
REQ-019 In IDLE, a select event SHALL clear the board, set turn=0, cursor=4, secs_left=TURN_SECS and enter PLAY.
REQ-020 In PLAY, a left event SHALL set cursor to cursor-1, wrapping 0->8; a right event SHALL set cursor+1, wrapping 8->0.
REQ-021 In PLAY, simultaneous left and right events SHALL leave cursor unchanged.
REQ-022 In PLAY, a select event on an empty cell SHALL write the mark of turn into that cell and enter CHECK; left/right events in the same cycle SHALL be ignored.
REQ-023 In PLAY, a select event on an occupied cell SHALL be ignored: no state change, timer keeps running.
REQ-024 In PLAY, each sec_tick event SHALL decrement secs_left; a tick at secs_left=1 SHALL toggle turn, reload TURN_SECS and place no mark.
REQ-025 In PLAY, a tick coinciding with an accepted select SHALL be dropped.
REQ-026 CHECK SHALL last exactly one cycle and evaluate the 8 lines (3 rows, 3 columns, 2 diagonals) on the updated board.
REQ-027 From CHECK, any line complete for the mover SHALL cause: winner = mover mark, win_mask = OR of all complete lines, secs_left=OVER_SECS, game_state=WIN.
REQ-028 From CHECK with no win and all 9 cells full SHALL cause: game_state=DRAW, winner=00, win_mask=0, secs_left=OVER_SECS.
REQ-029 From CHECK otherwise SHALL: toggle turn, reload secs_left=TURN_SECS, keep cursor, return to PLAY.
REQ-030 Events arriving during CHECK SHALL be discarded.
REQ-031 In OVER, each tick SHALL decrement secs_left; a tick at secs_left=1 or any select event SHALL enter IDLE.
REQ-032 In OVER, board, winner and win_mask SHALL be held until IDLE is entered.
REQ-033 Entering IDLE from OVER SHALL clear board, winner and win_mask and set secs_left=0; cursor holds.
REQ-034 left/right events outside PLAY SHALL be ignored.

Reset
REQ-035 While reset=0, regardless of clock: state IDLE, board=0, cursor=4, turn=0, game_state=00, winner=00, win_mask=0, secs_left=0, edge registers=0.
REQ-036 Reset asserted mid-game SHALL abort the game immediately; release SHALL NOT create an event for any input that is already high.

Verification
REQ-037 Release reset with select held high -> stays IDLE; select low then high -> PLAY, cursor=4, secs_left=10.
REQ-038 From cursor=8, right -> cursor=0; left -> cursor=8; left and right in the same cycle -> cursor=8.
REQ-039 X plays 0,1,2 and O plays 3,4 -> after CHECK: game_state=10, winner=01, win_mask=0x007, secs_left=3; 3 ticks -> IDLE, board=0.
REQ-040 Sequence X4,O0,X2,O6,X3,O5,X8,O1,X7 -> DRAW, winner=00, win_mask=0.
REQ-041 In PLAY with no select, 10 ticks -> turn toggles, board unchanged, secs_left=10; select on occupied cell -> no change.
REQ-042 Assert reset in CHECK or OVER -> all outputs return to reset values asynchronously.
